// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory-port arbiter.
//   arb_state_t  : sequencer states (ABORT is only reachable with ARB_TIMEOUT_EN)
//   NUM_REQ      : number of cache requesters sharing the port
//   REQ_ICACHE   : requester index of the instruction cache
//   REQ_DCACHE   : requester index of the data cache
//   idx_onehot() : requester index -> one-hot requester vector
package mem_arb_pkg;

  localparam int   NUM_REQ    = 2;
  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    WBURST = 3'd2,
    RBURST = 3'd3,
    DONE   = 3'd4,
    ABORT  = 3'd5
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic idx);
    idx_onehot = (idx == REQ_DCACHE) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin pick.
//   req      in  2  pending requests
//   last_gnt in  1  index of the requester that owned the port last
//   gnt      out 2  one-hot pick (0 when nothing is requested)
// A lone request always wins; on a tie the requester that did not go last wins.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_gnt,
  output logic [NUM_REQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == REQ_DCACHE) ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main-memory port between the instruction cache
// (requester 0) and the data cache (requester 1). Each grant covers a whole
// line burst of BEATS words; the port is re-arbitrated round-robin only after
// the burst completes.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req/we/addr/wdata   per-requester burst request, direction, line address,
//                       current write beat (requester i in slice i)
//   gnt                 one-hot owner, asserted from CMD through the last beat
//   wack/rvalid/rdata   per-beat write accept / read valid, shared read data
//   done/err            one-cycle burst complete / burst aborted pulses
//   mem_req/we/addr/ack memory command channel
//   mem_wvalid/wdata/wready  memory write beat channel
//   mem_rvalid/rdata    memory read beat channel
//   dbg_state           current sequencer state (arb_state_t encoding)
//
// Handshakes: a command transfers on the edge where mem_req && mem_ack; a
// write beat transfers where mem_wvalid && mem_wready; a read beat transfers
// where mem_rvalid is high in RBURST (mem_rvalid elsewhere is dropped). The
// requester side mirrors these: wack/rvalid are high exactly on the transfer
// cycle of the owning requester.
//
// Build option: define ARB_TIMEOUT_EN to abort any burst that spends TIMEOUT
// cycles in CMD/WBURST/RBURST; without it err is tied low and stalls wait forever.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BEATS   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        wack,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_ack,
  output logic                      mem_wvalid,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_wready,
  input  logic                      mem_rvalid,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [2:0]                dbg_state
);

  localparam int BW = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  arb_state_t          state;
  logic                g_idx;      // owner index, kept through DONE/ABORT
  logic                last_gnt;
  logic [BW-1:0]       beat_cnt;
  logic [NUM_REQ-1:0]  pick;
  logic                cur_idx;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                last_beat;

  rr_arbiter2 u_rr (
    .req      (req),
    .last_gnt (last_gnt),
    .gnt      (pick)
  );

  // In IDLE the command fields come from the requester being picked this
  // cycle; afterwards they track the owner so CMD re-samples every cycle.
  assign cur_idx   = (state == IDLE) ? pick[1] : g_idx;
  assign sel_we    = (cur_idx == REQ_ICACHE) ? we[0] : we[1];
  assign sel_addr  = (cur_idx == REQ_ICACHE) ? addr[ADDR_W-1:0]
                                             : addr[2*ADDR_W-1:ADDR_W];
  assign sel_wdata = (g_idx == REQ_ICACHE) ? wdata[DATA_W-1:0]
                                           : wdata[2*DATA_W-1:DATA_W];
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign dbg_state = state;

  // Beat-level outputs are decodes of the registered state, so they are
  // quiet outside their burst state and zero in reset.
  always_comb begin
    mem_wvalid = (state == WBURST);
    mem_wdata  = mem_wvalid ? sel_wdata : '0;
    rdata      = (state == RBURST) ? mem_rdata : '0;
    wack       = (state == WBURST && mem_wready) ? idx_onehot(g_idx) : '0;
    rvalid     = (state == RBURST && mem_rvalid) ? idx_onehot(g_idx) : '0;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;
  logic          in_burst;
  logic          finishing;

  assign in_burst  = (state == CMD) || (state == WBURST) || (state == RBURST);
  // A burst whose final beat lands on the timeout edge is reported as done.
  assign finishing = last_beat &&
                     (((state == WBURST) && mem_wready) ||
                      ((state == RBURST) && mem_rvalid));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign err = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      g_idx    <= REQ_ICACHE;
      last_gnt <= REQ_DCACHE;
      beat_cnt <= '0;
      gnt      <= '0;
      done     <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
`ifdef ARB_TIMEOUT_EN
      err      <= '0;
      tmo_cnt  <= '0;
`endif
    end else begin
      done <= '0;
`ifdef ARB_TIMEOUT_EN
      err  <= '0;
`endif
      case (state)
        IDLE: begin
          if (|pick) begin
            gnt      <= pick;
            g_idx    <= pick[1];
            mem_req  <= 1'b1;
            mem_we   <= sel_we;
            mem_addr <= sel_addr;
            state    <= CMD;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end
        end

        CMD: begin
          mem_we   <= sel_we;
          mem_addr <= sel_addr;
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= sel_we ? WBURST : RBURST;
          end
        end

        WBURST: begin
          if (mem_wready) begin
            if (last_beat) begin
              beat_cnt <= '0;
              gnt      <= '0;
              done     <= idx_onehot(g_idx);
              state    <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        RBURST: begin
          if (mem_rvalid) begin
            if (last_beat) begin
              beat_cnt <= '0;
              gnt      <= '0;
              done     <= idx_onehot(g_idx);
              state    <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        DONE: begin
          last_gnt <= g_idx;
          mem_we   <= 1'b0;
          mem_addr <= '0;
          state    <= IDLE;
        end

`ifdef ARB_TIMEOUT_EN
        ABORT: begin
          last_gnt <= g_idx;
          state    <= IDLE;
        end
`endif

        default: state <= IDLE;
      endcase

`ifdef ARB_TIMEOUT_EN
      // Placed after the case so an abort overrides whatever the burst
      // states scheduled on this edge.
      if (in_burst) begin
        if (tmo_cnt == TMO_LAST && !finishing) begin
          state    <= ABORT;
          err      <= idx_onehot(g_idx);
          gnt      <= '0;
          mem_req  <= 1'b0;
          mem_we   <= 1'b0;
          mem_addr <= '0;
          beat_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter (BEATS=8).
// Inputs are driven 1ns after each rising edge and outputs sampled 2ns after
// it, so every sample shows the state the next edge will act on.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req, we;
  logic [63:0] addr, wdata;
  logic [1:0]  gnt, wack, rvalid, done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we, mem_ack, mem_wvalid, mem_wready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  dbg_state;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .BEATS(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .wack(wack), .rvalid(rvalid), .rdata(rdata), .done(done),
    .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata),
    .mem_wready(mem_wready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_rvalid = 0, n_wack = 0, n_done = 0, n_err = 0, n_req_rise = 0;
  logic        prev_req = 1'b0;
  logic [1:0]  prev_gnt = 2'b00;
  logic [1:0]  adv_w = 2'b00;
  logic [31:0] exp_q[$];    // expected read beats
  logic [31:0] wexp_q[$];   // expected write beats
  logic [1:0]  gnt_log[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    prev_req = 1'b0; prev_gnt = 2'b00; adv_w = 2'b00;
    n_req_rise = n_done + n_err;
  endtask

  // one clock: drive memory-side inputs, then observe and score
  task automatic cyc(input logic ack, input logic wr, input logic rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    if (adv_w[0]) wdata[31:0]  = wdata[31:0] + 32'd1;
    if (adv_w[1]) wdata[63:32] = wdata[63:32] + 32'd1;
    adv_w = 2'b00;
    mem_ack = ack; mem_wready = wr; mem_rvalid = rv; mem_rdata = rd;
    #1;
    if (|rvalid) begin
      n_rvalid++;
      check("rvalid_owner", 64'(rvalid), 64'(gnt));
      if (exp_q.size() == 0) check("rdata_extra", 64'(rdata), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("rdata", 64'(rdata), 64'(exp_q.pop_front()));
    end
    if (|wack) begin
      n_wack++;
      check("wack_owner", 64'(wack), 64'(gnt));
      if (wexp_q.size() == 0) check("wdata_extra", 64'(mem_wdata), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("mem_wdata", 64'(mem_wdata), 64'(wexp_q.pop_front()));
      adv_w = wack;
    end
    if (|done) n_done++;
    if (|err) n_err++;
    if (mem_req && !prev_req) begin
      n_req_rise++;
      check("done_before_req", 64'(n_done + n_err), 64'(n_req_rise - 1));
    end
    if ((|gnt) && (prev_gnt == 2'b00)) gnt_log.push_back(gnt);
    prev_req = mem_req;
    prev_gnt = gnt;
  endtask

  // full read burst for one requester; junk drives mem_rvalid during CMD
  task automatic read_burst(input logic idx, input logic [31:0] a, input int ack_delay,
                            input logic junk, input logic [31:0] base);
    logic [1:0] oh;
    int r0, d0;
    oh = idx ? 2'b10 : 2'b01;
    r0 = n_rvalid; d0 = n_done;
    for (int i = 0; i < 8; i++) exp_q.push_back(base + 32'(i));
    we[idx] = 1'b0;
    if (idx) addr[63:32] = a; else addr[31:0] = a;
    req[idx] = 1'b1;
    cyc(ack_delay == 0, 1'b0, junk, 32'hDEAD_BEEF);
    check("rd_cmd_state", 64'(dbg_state), 64'(3'd1));
    check("rd_cmd_req", 64'(mem_req), 64'(1'b1));
    check("rd_cmd_addr", 64'(mem_addr), 64'(a));
    check("rd_cmd_we", 64'(mem_we), 64'(1'b0));
    check("rd_cmd_gnt", 64'(gnt), 64'(oh));
    for (int i = 1; i <= ack_delay; i++) cyc(i == ack_delay, 1'b0, junk, 32'hDEAD_BEEF);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, base + 32'(i));
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("rd_done", 64'(done), 64'(oh));
    check("rd_gnt_clear", 64'(gnt), 64'(2'b00));
    req[idx] = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("rd_idle", 64'(dbg_state), 64'(3'd0));
    check("rd_beats", 64'(n_rvalid - r0), 64'(8));
    check("rd_done_cnt", 64'(n_done - d0), 64'(1));
  endtask

  initial begin
    int w0, d0, e0, hit;

    // reset state
    do_reset();
    #1;
    check("rst_ctl", 64'({gnt, wack, rvalid, done, err, mem_req, mem_we, mem_wvalid}), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));

    // fetch burst, icache, ack after 2 cycles
    read_burst(1'b0, 32'h0000_1000, 2, 1'b0, 32'hA0);

    // mem_rvalid during CMD is ignored
    read_burst(1'b0, 32'h0000_3000, 3, 1'b1, 32'hC0);

    // writeback burst, dcache, wready toggling
    w0 = n_wack; d0 = n_done;
    wdata[63:32] = 32'hB0;
    for (int i = 0; i < 8; i++) wexp_q.push_back(32'hB0 + 32'(i));
    we = 2'b10; addr[63:32] = 32'h0000_2040; req = 2'b10;
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("wr_cmd_we", 64'(mem_we), 64'(1'b1));
    check("wr_cmd_addr", 64'(mem_addr), 64'(32'h0000_2040));
    check("wr_cmd_gnt", 64'(gnt), 64'(2'b10));
    for (int c = 0; c < 40 && n_wack < w0 + 8; c++) cyc(1'b0, c[0] == 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("wr_done", 64'(done), 64'(2'b10));
    req = 2'b00; we = 2'b00;
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("wr_wacks", 64'(n_wack - w0), 64'(8));
    check("wr_done_cnt", 64'(n_done - d0), 64'(1));
    check("wr_q_empty", 64'(wexp_q.size()), 64'(0));

    // tie after reset: grants alternate 0,1,0,1
    do_reset();
    gnt_log.delete();
    d0 = n_done;
    for (int i = 0; i < 32; i++) exp_q.push_back(32'hF0);
    we = 2'b00; addr = {32'h0000_0200, 32'h0000_0100}; req = 2'b11;
    for (int c = 0; c < 100 && n_done < d0 + 4; c++) cyc(1'b1, 1'b0, 1'b1, 32'hF0);
    req = 2'b00;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("tie_dones", 64'(n_done - d0), 64'(4));
    check("tie_grants", 64'(gnt_log.size()), 64'(4));
    if (gnt_log.size() == 4) begin
      check("tie_g0", 64'(gnt_log[0]), 64'(2'b01));
      check("tie_g1", 64'(gnt_log[1]), 64'(2'b10));
      check("tie_g2", 64'(gnt_log[2]), 64'(2'b01));
      check("tie_g3", 64'(gnt_log[3]), 64'(2'b10));
    end
    check("tie_q_empty", 64'(exp_q.size()), 64'(0));

    // command stall, then reset mid-burst
    do_reset();
    d0 = n_done;
    we = 2'b00; addr[31:0] = 32'h0000_5000; req = 2'b01;
    for (int c = 0; c < 20; c++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("stall_state", 64'(dbg_state), 64'(3'd1));
    check("stall_req", 64'(mem_req), 64'(1'b1));
    rst = 1'b0;
    #2;
    check("mid_rst_ctl", 64'({gnt, wack, rvalid, done, err, mem_req, mem_we, mem_wvalid}), 64'(0));
    check("mid_rst_data", 64'({mem_addr, mem_wdata}), 64'(0));
    check("mid_rst_rdata", 64'(rdata), 64'(0));
    #8 rst = 1'b1;
    req = 2'b00; prev_req = 1'b0; prev_gnt = 2'b00;
    n_req_rise = n_done + n_err;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("mid_rst_nodone", 64'(n_done - d0), 64'(0));
    read_burst(1'b0, 32'h0000_6000, 0, 1'b0, 32'hE0);

`ifdef ARB_TIMEOUT_EN
    // command never acked: err 16 cycles after CMD entry, then other side wins
    do_reset();
    d0 = n_done; e0 = n_err; hit = 0;
    we = 2'b00; addr[31:0] = 32'h0000_7000; req = 2'b01;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 1; k <= 40; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      if (|err) begin
        hit = k;
        break;
      end
    end
    check("tmo_cycles", 64'(hit), 64'(16));
    check("tmo_err", 64'(err), 64'(2'b01));
    check("tmo_nodone", 64'(n_done - d0), 64'(0));
    req = 2'b11;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("tmo_next_gnt", 64'(gnt), 64'(2'b10));
    check("tmo_err_cnt", 64'(n_err - e0), 64'(1));
    do_reset();
`else
    e0 = 0; hit = 0;
    check("err_none", 64'(n_err + e0 + hit), 64'(0));
`endif

    check("rd_q_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between two cache controllers: requester 0 is the instruction cache and requester 1 is the data cache.
- Each requester issues whole-line read (fetch) or write (writeback) bursts of BEATS words.
- Arbitration is round-robin at burst granularity. A granted burst runs to completion before the port is re-arbitrated.
- Sits between the cache controllers' mem_read/mem_write/response handshake and the memory interface.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, beat data width
BEATS, 8, words per line burst (power of 2, >=2)
TIMEOUT, 64, max cycles per burst before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
req  in  2  burst request per requester; held until done
we  in  2  1 = writeback burst, 0 = fetch burst; stable while req
addr  in  2*ADDR_W  line address; requester i in bits [i*ADDR_W +: ADDR_W]
wdata  in  2*DATA_W  current write beat per requester
gnt  out  2  one-hot; the requester that owns the port
wack  out  2  write beat accepted; requester advances wdata next cycle
rvalid  out  2  read beat valid for requester
rdata  out  DATA_W  read beat data (shared)
done  out  2  one-cycle pulse: burst complete
err  out  2  one-cycle pulse: burst aborted (ARB_TIMEOUT_EN only; tied 0 otherwise)
mem_req  out  1  command valid
mem_we  out  1  command is write
mem_addr  out  ADDR_W  command line address
mem_ack  in  1  command accepted
mem_wvalid  out  1  write beat valid
mem_wdata  out  DATA_W  write beat
mem_wready  in  1  write beat accepted
mem_rvalid  in  1  read beat valid
mem_rdata  in  DATA_W  read beat

Behaviour:
- Reset values: all outputs 0. state=IDLE. beat_cnt=0. last_gnt=1, so requester 0 wins the first tie. Reset mid-burst aborts immediately with no done; memory-side recovery is outside this block.
- States:
  - IDLE: no req -> stay. One req -> grant it. Both req -> grant !last_gnt. Registered gnt, mem_req, mem_we, mem_addr are asserted the next cycle -> CMD.
  - CMD: hold mem_req/mem_we/mem_addr from the granted requester. On mem_ack: drop mem_req, then -> WBURST if we, else RBURST.
  - WBURST:
    - mem_wvalid=1, mem_wdata=wdata[g].
    - wack[g] = mem_wready (combinational, only in WBURST). beat_cnt increments on mem_wvalid && mem_wready.
    - The beat accepted with beat_cnt==BEATS-1 -> DONE.
  - RBURST:
    - rvalid[g] = mem_rvalid, rdata = mem_rdata (combinational passthrough). beat_cnt increments per mem_rvalid.
    - The last beat -> DONE.
    - mem_rvalid outside RBURST is ignored.
  - DONE: done[g]=1 for one cycle. gnt cleared. last_gnt=g. beat_cnt=0. -> IDLE.
- Minimum occupancy per burst: 1 (IDLE) + 1 (CMD with immediate ack) + BEATS + 1 (DONE) cycles.
- gnt stays asserted from CMD through the last burst beat.
- req/we/addr of the granted requester are sampled every cycle in CMD. Requesters must hold them stable. Deasserting req after grant does not cancel the burst.
- A requester reasserting req the cycle after done competes normally. Under continuous contention, grants alternate 0,1,0,1.
- mem_ack, mem_wready, or mem_rvalid may stall indefinitely. Without the optional feature there is no abort.
- beat_cnt width is $clog2(BEATS). It wraps to 0 only via DONE.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to CMD and increments in CMD, WBURST, and RBURST.
  - Reaching TIMEOUT -> ABORT state. ABORT pulses err[g] for 1 cycle (no done), clears gnt/mem_* and beat_cnt, sets last_gnt=g, then -> IDLE.
- Undefined: no counter, no ABORT state, err tied to 0.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, CMD, WBURST, RBURST, DONE, ABORT).
  - NUM_REQ=2.
  - REQ_ICACHE=0, REQ_DCACHE=1.
- Sub-module rr_arbiter2: combinational 2-way round-robin pick from req and last_gnt, producing a one-hot grant. All sequencing stays in mem_port_arbiter.

Test Plan:
- Fetch burst: req=2'b01, we=0, addr0=0x0000_1000; mem_ack after 2 cycles; 8 mem_rvalid beats 0xA0..0xA7 back-to-back -> rvalid[0] 8 times with matching rdata, done[0] one pulse, gnt returns to 0.
- Writeback burst: req1 with we=1, addr=0x0000_2040; mem_wready toggles 1,0,1,0... -> exactly 8 wack[1] pulses, each beat's mem_wdata equal to wdata1 at acceptance, then done[1].
- Tie after reset: req=2'b11 held continuously -> grant order 0,1,0,1. No burst overlaps. Each done precedes the next mem_req.
- Stall then reset: hold mem_ack=0 for 20 cycles, then drive rst=0 for 1 cycle -> all outputs 0, no done; the next req=2'b01 is granted normally.
- With ARB_TIMEOUT_EN, TIMEOUT=16: mem_ack never asserted -> err[g] pulse 16 cycles after CMD entry, no done; the other requester is granted next.
- Command/read overlap: mem_rvalid pulses while in CMD -> ignored; beat count still needs 8 beats in RBURST.
